// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the shared 64x8 dffram: Wishbone (W) and design (D) ports.
// Registered ownership FSM with burst fairness; grants and SRAM controls are combinational.
module sram_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          d_en,
  input  logic          w_req,
  input  logic          w_we,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_wdata,
  output logic          w_gnt,
  output logic          w_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic          sram_cen,
  output logic          sram_gwen,
  output logic [DW-1:0] sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic [1:0]    owner,
  output logic [15:0]   stall_cnt
);

  localparam int BCW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0] BURST_SAT  = BCW'(BURST_MAX);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_W = 2'b01,
    ST_OWN_D = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_d;
  logic            w_last_d_nxt;
  logic [BCW-1:0]  r_burst_cnt;
  logic [BCW-1:0]  w_burst_nxt;
  logic [BCW-1:0]  w_burst_inc;
  logic            r_w_rvalid;
  logic            r_d_rvalid;
  logic [15:0]     r_stall_cnt;
  logic            w_dreq_en;
  logic            w_stall;
  logic            w_burst_done;

  // A disabled D port is indistinguishable from one that is not requesting.
  assign w_dreq_en    = d_req & d_en;
  assign w_gnt        = (r_state == ST_OWN_W) & w_req;
  assign d_gnt        = (r_state == ST_OWN_D) & w_dreq_en;
  assign w_burst_inc  = (r_burst_cnt == BURST_SAT) ? r_burst_cnt : r_burst_cnt + 1'b1;
  assign w_burst_done = (r_burst_cnt >= BURST_LAST);
  assign w_stall      = (w_req & ~w_gnt) | (w_dreq_en & ~d_gnt);

  assign w_rvalid  = r_w_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign rdata     = sram_q;
  assign sram_wen  = '0;
  assign owner     = r_state;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    if (w_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = ~w_we;
      sram_a    = w_addr;
      sram_d    = w_wdata;
    end else if (d_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = ~d_we;
      sram_a    = d_addr;
      sram_d    = d_wdata;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_burst_nxt  = r_burst_cnt;
    w_last_d_nxt = r_last_d;
    case (r_state)
      ST_IDLE: begin
        w_burst_nxt = '0;
        // On a tie the port that did not own the SRAM last goes first.
        if (w_req && (!w_dreq_en || r_last_d)) begin
          w_state_nxt = ST_OWN_W;
        end else if (w_dreq_en) begin
          w_state_nxt = ST_OWN_D;
        end
      end
      ST_OWN_W: begin
        if (!w_req) begin
          w_last_d_nxt = 1'b0;
          w_burst_nxt  = '0;
          w_state_nxt  = w_dreq_en ? ST_OWN_D : ST_IDLE;
        end else if (w_burst_done && w_dreq_en) begin
          w_last_d_nxt = 1'b0;
          w_burst_nxt  = '0;
          w_state_nxt  = ST_OWN_D;
        end else begin
          w_burst_nxt = w_burst_inc;
        end
      end
      ST_OWN_D: begin
        if (!w_dreq_en) begin
          w_last_d_nxt = 1'b1;
          w_burst_nxt  = '0;
          w_state_nxt  = w_req ? ST_OWN_W : ST_IDLE;
        end else if (w_burst_done && w_req) begin
          w_last_d_nxt = 1'b1;
          w_burst_nxt  = '0;
          w_state_nxt  = ST_OWN_W;
        end else begin
          w_burst_nxt = w_burst_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= ST_IDLE;
      r_last_d    <= 1'b1;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_d    <= w_last_d_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_w_rvalid  <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_w_rvalid <= w_gnt & ~w_we;
      r_d_rvalid <= d_gnt & ~d_we;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of ownership, fairness, stall counting and memory contents.
module tb_sram_arbiter;

  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int BMAX = 4;

  logic          clk;
  logic          rst_n;
  logic          d_en;
  logic          w_req, w_we, d_req, d_we;
  logic [AW-1:0] w_addr, d_addr;
  logic [DW-1:0] w_wdata, d_wdata;
  logic          w_gnt, w_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] rdata;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;
  logic [1:0]    owner;
  logic [15:0]   stall_cnt;

  sram_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BMAX)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .d_en     (d_en),
    .w_req    (w_req),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_wdata  (w_wdata),
    .w_gnt    (w_gnt),
    .w_rvalid (w_rvalid),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .rdata    (rdata),
    .sram_cen (sram_cen),
    .sram_gwen(sram_gwen),
    .sram_wen (sram_wen),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_q   (sram_q),
    .owner    (owner),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dffram behaviour: synchronous write, read data appears after the edge
  logic [DW-1:0] sram_mem [64];
  initial begin
    for (int i = 0; i < 64; i++) sram_mem[i] = '0;
    sram_q = '0;
  end
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= sram_d;
      else            sram_q <= sram_mem[sram_a];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: owner 0 none, 1 W, 2 D; run = accesses in current tenure
  int            m_own, m_last, m_run, m_stall;
  bit            m_wrv, m_drv, m_gw, m_gd;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [64];

  task automatic model_reset();
    m_own = 0; m_last = 2; m_run = 0; m_stall = 0;
    m_wrv = 0; m_drv = 0; m_gw = 0; m_gd = 0;
  endtask

  // Called mid-cycle with inputs settled; checks this cycle, then advances the model.
  task automatic step();
    bit dr, gw, gd, acc, awe, mine, theirs;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    #1;
    dr = d_req && d_en;
    gw = (m_own == 1) && w_req;
    gd = (m_own == 2) && dr;
    acc = gw || gd;
    awe = gw ? w_we : d_we;
    aa  = gw ? w_addr : d_addr;
    ad  = gw ? w_wdata : d_wdata;
    check_val("w_gnt", w_gnt, gw);
    check_val("d_gnt", d_gnt, gd);
    check_val("owner", owner, m_own);
    check_val("stall_cnt", stall_cnt, m_stall);
    check_val("w_rvalid", w_rvalid, m_wrv);
    check_val("d_rvalid", d_rvalid, m_drv);
    if (m_wrv || m_drv) check_val("rdata", rdata, m_rdata);
    check_val("sram_cen", sram_cen, !acc);
    check_val("sram_wen", sram_wen, 0);
    if (acc) begin
      check_val("sram_gwen", sram_gwen, !awe);
      check_val("sram_a", sram_a, aa);
      if (awe) check_val("sram_d", sram_d, ad);
    end else begin
      check_val("sram_gwen_idle", sram_gwen, 1);
    end

    if (((w_req && !gw) || (dr && !gd)) && m_stall < 65535) m_stall++;
    m_wrv = gw && !w_we;
    m_drv = gd && !d_we;
    if (acc) begin
      if (awe) m_mem[aa] = ad;
      else     m_rdata = m_mem[aa];
    end
    if (m_own == 0) begin
      m_run = 0;
      if (w_req && dr) m_own = (m_last == 1) ? 2 : 1;
      else if (w_req)  m_own = 1;
      else if (dr)     m_own = 2;
    end else begin
      mine   = (m_own == 1) ? w_req : dr;
      theirs = (m_own == 1) ? dr : w_req;
      if (!mine) begin
        m_last = m_own;
        m_own  = theirs ? 3 - m_own : 0;
        m_run  = 0;
      end else begin
        m_run = (m_run < BMAX) ? m_run + 1 : BMAX;
        if (m_run >= BMAX && theirs) begin
          m_last = m_own;
          m_own  = 3 - m_own;
          m_run  = 0;
        end
      end
    end
    m_gw = gw;
    m_gd = gd;
  endtask

  task automatic cyc(input bit wr, input bit ww, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                     input bit de);
    @(negedge clk);
    w_req = wr; w_we = ww; w_addr = wa; w_wdata = wd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    d_en = de;
    step();
  endtask

  task automatic check_reset_outs(input string pfx);
    check_val({pfx, "_w_gnt"}, w_gnt, 0);
    check_val({pfx, "_d_gnt"}, d_gnt, 0);
    check_val({pfx, "_w_rvalid"}, w_rvalid, 0);
    check_val({pfx, "_d_rvalid"}, d_rvalid, 0);
    check_val({pfx, "_cen"}, sram_cen, 1);
    check_val({pfx, "_gwen"}, sram_gwen, 1);
    check_val({pfx, "_a"}, sram_a, 0);
    check_val({pfx, "_d"}, sram_d, 0);
    check_val({pfx, "_owner"}, owner, 0);
    check_val({pfx, "_stall"}, stall_cnt, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    w_req = 0; d_req = 0;
    #1 check_reset_outs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic agent();
    if (m_gw || !w_req) begin
      if ($urandom_range(0, 99) < 60) begin
        w_req = 1'b1; w_we = 1'($urandom_range(0, 1));
        w_addr = 6'($urandom_range(0, 7)); w_wdata = 8'($urandom);
      end else w_req = 1'b0;
    end else if ($urandom_range(0, 15) == 0) w_req = 1'b0;
    if (m_gd || !d_req) begin
      if ($urandom_range(0, 99) < 60) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 6'($urandom_range(0, 7)); d_wdata = 8'($urandom);
      end else d_req = 1'b0;
    end else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
    if ($urandom_range(0, 39) == 0) d_en = ~d_en;
  endtask

  initial begin
    bit eb;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    model_reset();
    rst_n = 1'b0; d_en = 1'b1;
    w_req = 0; w_we = 0; w_addr = '0; w_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    #2 check_reset_outs("por");
    apply_reset();

    // W write 5=A5 then read it back
    cyc(1, 1, 6'd5, 8'hA5, 0, 0, 6'd0, 8'h00, 1);
    check_val("wr_bubble_gnt", w_gnt, 0);
    cyc(1, 1, 6'd5, 8'hA5, 0, 0, 6'd0, 8'h00, 1);
    check_val("wr_gnt", w_gnt, 1);
    check_val("wr_cen", sram_cen, 0);
    check_val("wr_gwen", sram_gwen, 0);
    check_val("wr_a", sram_a, 5);
    check_val("wr_d", sram_d, 8'hA5);
    cyc(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00, 1);
    check_val("rd_gnt", w_gnt, 1);
    check_val("wr_no_rvalid", w_rvalid, 0);
    cyc(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 1);
    check_val("rd_rvalid", w_rvalid, 1);
    check_val("rd_data", rdata, 8'hA5);
    check_val("rd_stall", stall_cnt, 1);
    cyc(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 1);

    // Both ports hold requests: bursts of BMAX alternate, W first
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      cyc(1, 0, 6'd5, 8'h00, 1, 0, 6'd3, 8'h00, 1);
      eb = (k > 0) && (((k - 1) / BMAX) % 2 == 0);
      check_val("burst_w", w_gnt, eb);
      check_val("burst_d", d_gnt, (k > 0) && !eb);
    end

    // Disabled D port requesting: nothing happens
    apply_reset();
    for (int k = 0; k < 10; k++) cyc(0, 0, 6'd0, 8'h00, 1, 0, 6'd9, 8'h00, 0);
    check_val("den0_owner", owner, 0);
    check_val("den0_gnt", d_gnt, 0);
    check_val("den0_stall", stall_cnt, 0);

    // Reset right after a D read grant drops the access
    cyc(0, 0, 6'd0, 8'h00, 1, 0, 6'd9, 8'h00, 1);
    cyc(0, 0, 6'd0, 8'h00, 1, 0, 6'd9, 8'h00, 1);
    check_val("rstmid_gnt", d_gnt, 1);
    rst_n = 1'b0;
    #1 check_reset_outs("rstmid");
    @(posedge clk);
    #1 check_val("rstmid_rvalid", d_rvalid, 0);
    check_val("rstmid_cen", sram_cen, 1);
    @(negedge clk);
    d_req = 0;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic
    m_gw = 0; m_gd = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      agent();
      step();
    end

    // Continuous contention until stall_cnt saturates
    apply_reset();
    for (int k = 0; k < 65600; k++) cyc(1, 0, 6'd1, 8'h00, 1, 0, 6'd2, 8'h00, 1);
    check_val("stall_sat", stall_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
